// File: rtl/ram_half_bank_ctrl.sv
// ram_half_bank_ctrl
//   Initiator-side controller for a data memory built from two 16-bit
//   half-word banks (upper bank = word bits 31:16, lower bank = 15:0).
//   Takes one CPU load/store at a time (byte, half or word), drives both
//   banks and returns extended load data. Byte order is big-endian: addr[1]=0
//   picks the upper bank, and within a half addr[0]=0 is bits 15:8.
//   Byte stores are done as read-modify-write on the selected bank.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_req               request strobe, sampled only while o_ready=1
//   i_wr                1=store, 0=load
//   i_size              0=byte, 1=half, 2=word, 3=reserved (misaligned)
//   i_sext              load sign-extend (1) or zero-extend (0)
//   i_addr              byte address, ADDR_W+2 bits
//   i_wdata             store data (byte in [7:0], half in [15:0])
//   o_ready             controller idle
//   o_done              one-cycle completion pulse
//   o_err               misaligned/reserved flag, valid with o_done
//   o_rdata             load result, held until the next load completes
//   o_ram_addr          word address to both banks
//   o_ram_d_hi/_lo      write data per bank
//   o_ram_we            shared write enable
//   o_ram_sel_hi/_lo    bank selects
//   i_ram_q_hi/_lo      bank read data (asynchronous read)

module ram_half_bank_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic              i_sext,
    input  logic [ADDR_W+1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [15:0]       o_ram_d_hi,
    output logic [15:0]       o_ram_d_lo,
    output logic              o_ram_we,
    output logic              o_ram_sel_hi,
    output logic              o_ram_sel_lo,
    input  logic [15:0]       i_ram_q_hi,
    input  logic [15:0]       i_ram_q_lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RMW  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_sext;
    logic [1:0]         r_size;
    logic [ADDR_W+1:0]  r_addr;
    logic [31:0]        r_wdata;

    logic [15:0]        w_q_sel;
    logic [15:0]        w_merged;
    logic [31:0]        w_load;
    logic               w_misaligned;

    // Reserved size is always an error; half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = (a != 2'd0);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Replace one byte of a half-word; a0=0 addresses the high byte.
    function automatic logic [15:0] f_merge(input logic [15:0] half, input logic a0,
                                           input logic [7:0] b);
        logic [15:0] m;
        if (a0) begin
            m = {half[15:8], b};
        end else begin
            m = {b, half[7:0]};
        end
        return m;
    endfunction

    // Pick the addressed byte/half out of the two bank outputs and extend it.
    function automatic logic [31:0] f_extract(input logic [1:0] size, input logic sext,
                                             input logic [1:0] a, input logic [15:0] q_hi,
                                             input logic [15:0] q_lo);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? q_lo : q_hi;
        b = a[0] ? h[7:0] : h[15:8];
        case (size)
            2'd0:    r = {{24{sext & b[7]}}, b};
            2'd1:    r = {{16{sext & h[15]}}, h};
            default: r = {q_hi, q_lo};
        endcase
        return r;
    endfunction

    assign w_q_sel      = r_addr[1] ? i_ram_q_lo : i_ram_q_hi;
    assign w_merged     = f_merge(w_q_sel, r_addr[0], r_wdata[7:0]);
    assign w_load       = f_extract(r_size, r_sext, r_addr[1:0], i_ram_q_hi, i_ram_q_lo);
    assign w_misaligned = f_misaligned(i_size, i_addr[1:0]);

    // Access sequencer: state, latched request and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sext       <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            o_ready      <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_rdata      <= 32'd0;
            o_ram_addr   <= '0;
            o_ram_d_hi   <= 16'd0;
            o_ram_d_lo   <= 16'd0;
            o_ram_we     <= 1'b0;
            o_ram_sel_hi <= 1'b0;
            o_ram_sel_lo <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_sext     <= i_sext;
                        r_size     <= i_size;
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        o_ready    <= 1'b0;
                        o_ram_addr <= i_addr[ADDR_W+1:2];
                        if (w_misaligned) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                        end else if (!i_wr) begin
                            r_state <= S_RD;
                        end else if (i_size == 2'd0) begin
                            r_state <= S_RMW;
                        end else begin
                            // Half/word store data is known now, so WR outputs
                            // are set on the accepting edge.
                            r_state  <= S_WR;
                            o_ram_we <= 1'b1;
                            if (i_size == 2'd2) begin
                                o_ram_sel_hi <= 1'b1;
                                o_ram_sel_lo <= 1'b1;
                                o_ram_d_hi   <= i_wdata[31:16];
                                o_ram_d_lo   <= i_wdata[15:0];
                            end else if (i_addr[1]) begin
                                o_ram_sel_lo <= 1'b1;
                                o_ram_d_lo   <= i_wdata[15:0];
                            end else begin
                                o_ram_sel_hi <= 1'b1;
                                o_ram_d_hi   <= i_wdata[15:0];
                            end
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    o_rdata <= w_load;
                    o_done  <= 1'b1;
                    o_err   <= 1'b0;
                    r_state <= S_DONE;
                end
                S_RMW: begin
                    // Merged half goes straight into the WR data register.
                    r_state  <= S_WR;
                    o_ram_we <= 1'b1;
                    if (r_addr[1]) begin
                        o_ram_sel_lo <= 1'b1;
                        o_ram_d_lo   <= w_merged;
                    end else begin
                        o_ram_sel_hi <= 1'b1;
                        o_ram_d_hi   <= w_merged;
                    end
                end
                S_WR: begin
                    o_ram_we     <= 1'b0;
                    o_ram_sel_hi <= 1'b0;
                    o_ram_sel_lo <= 1'b0;
                    o_ram_d_hi   <= 16'd0;
                    o_ram_d_lo   <= 16'd0;
                    o_done       <= 1'b1;
                    o_err        <= 1'b0;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    o_done     <= 1'b0;
                    o_err      <= 1'b0;
                    o_ready    <= 1'b1;
                    o_ram_addr <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_ready      <= 1'b1;
                    o_done       <= 1'b0;
                    o_err        <= 1'b0;
                    o_ram_addr   <= '0;
                    o_ram_we     <= 1'b0;
                    o_ram_sel_hi <= 1'b0;
                    o_ram_sel_lo <= 1'b0;
                    o_ram_d_hi   <= 16'd0;
                    o_ram_d_lo   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_half_bank_ctrl.sv
// Self-checking bench for ram_half_bank_ctrl: two behavioural half-word banks
// plus a byte-addressed big-endian reference memory model.
module tb_ram_half_bank_ctrl;

    localparam int ADDR_W = 10;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              i_req;
    logic              i_wr;
    logic [1:0]        i_size;
    logic              i_sext;
    logic [ADDR_W+1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_ready;
    logic              o_done;
    logic              o_err;
    logic [31:0]       o_rdata;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [15:0]       o_ram_d_hi;
    logic [15:0]       o_ram_d_lo;
    logic              o_ram_we;
    logic              o_ram_sel_hi;
    logic              o_ram_sel_lo;
    logic [15:0]       i_ram_q_hi;
    logic [15:0]       i_ram_q_lo;

    logic [15:0] bank_hi [NWORDS];
    logic [15:0] bank_lo [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] exp_rdata;

    int n_checks;
    int n_errors;

    ram_half_bank_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_wr(i_wr), .i_size(i_size),
        .i_sext(i_sext), .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready),
        .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_ram_addr(o_ram_addr),
        .o_ram_d_hi(o_ram_d_hi), .o_ram_d_lo(o_ram_d_lo), .o_ram_we(o_ram_we),
        .o_ram_sel_hi(o_ram_sel_hi), .o_ram_sel_lo(o_ram_sel_lo),
        .i_ram_q_hi(i_ram_q_hi), .i_ram_q_lo(i_ram_q_lo)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank models: asynchronous read, write on rising edge when selected.
    assign i_ram_q_hi = bank_hi[o_ram_addr];
    assign i_ram_q_lo = bank_lo[o_ram_addr];
    always @(posedge clk) begin
        if (o_ram_we && o_ram_sel_hi) bank_hi[o_ram_addr] <= o_ram_d_hi;
        if (o_ram_we && o_ram_sel_lo) bank_lo[o_ram_addr] <= o_ram_d_lo;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [11:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    // Big-endian load: byte k of a word lives at bits 31-8k..24-8k.
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx,
                                             input logic [11:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int k;
        w = ref_mem[a / 4];
        k = a % 4;
        if (sz == 2'd2) return w;
        if (sz == 2'd1) begin
            v = (w >> (16 * (1 - k / 2))) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v - 32'h10000;
            return v;
        end
        v = (w >> (8 * (3 - k))) & 32'hFF;
        if (sx && v >= 32'h80) v = v - 32'h100;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [1:0] sz, input logic [11:0] a,
                                              input logic [31:0] wd);
        logic [31:0] w;
        logic [31:0] mask;
        int sh;
        int k;
        w = ref_mem[a / 4];
        k = a % 4;
        if (sz == 2'd2) return wd;
        if (sz == 2'd1) begin
            sh = 16 * (1 - k / 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        sh = 8 * (3 - k);
        mask = 32'hFF << sh;
        return (w & ~mask) | ((wd & 32'hFF) << sh);
    endfunction

    // One complete access: issue, follow it to done, check everything.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [11:0] a, input logic [31:0] wd);
        int n;
        int lat;
        int exp_lat;
        int we_cnt;
        logic e;
        logic [31:0] new_w;
        logic [15:0] nh;
        logic [15:0] nl;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_before", {31'd0, o_ready}, 32'd1);
        e = ref_misaligned(sz, a);
        new_w = ref_store(sz, a, wd);
        nh = new_w[31:16];
        nl = new_w[15:0];
        if (e) exp_lat = 1;
        else if (w && sz == 2'd0) exp_lat = 3;
        else exp_lat = 2;
        i_req = 1'b1; i_wr = w; i_size = sz; i_sext = sx; i_addr = a; i_wdata = wd;
        @(negedge clk);
        i_req = 1'b0;
        i_wdata = $urandom;
        lat = 1;
        we_cnt = 0;
        while (!o_done && lat < 8) begin
            check_val("ready_busy", {31'd0, o_ready}, 32'd0);
            if (o_ram_we) begin
                we_cnt++;
                check_val("wr_addr", {22'd0, o_ram_addr}, {22'd0, a[11:2]});
                if (sz == 2'd2) begin
                    check_val("wr_sel", {30'd0, o_ram_sel_hi, o_ram_sel_lo}, 32'd3);
                    check_val("wr_d", {o_ram_d_hi, o_ram_d_lo}, new_w);
                end else if (a[1]) begin
                    check_val("wr_sel", {30'd0, o_ram_sel_hi, o_ram_sel_lo}, 32'd1);
                    check_val("wr_d", {o_ram_d_hi, o_ram_d_lo}, {16'd0, nl});
                end else begin
                    check_val("wr_sel", {30'd0, o_ram_sel_hi, o_ram_sel_lo}, 32'd2);
                    check_val("wr_d", {o_ram_d_hi, o_ram_d_lo}, {nh, 16'd0});
                end
            end
            @(negedge clk);
            lat++;
        end
        check_val("latency", lat, exp_lat);
        check_val("done_ready", {30'd0, o_done, o_ready}, 32'd2);
        check_val("err", {31'd0, o_err}, {31'd0, e});
        check_val("we_count", we_cnt, (w && !e) ? 1 : 0);
        if (!e && w) ref_mem[a / 4] = new_w;
        if (!e && !w) exp_rdata = ref_load(sz, sx, a);
        check_val("rdata", o_rdata, exp_rdata);
        check_val("mem", {bank_hi[a / 4], bank_lo[a / 4]}, ref_mem[a / 4]);
    endtask

    initial begin
        int idx_q[$];
        n_checks = 0;
        n_errors = 0;
        exp_rdata = 32'd0;
        i_req = 1'b0; i_wr = 1'b0; i_size = 2'd0; i_sext = 1'b0; i_addr = '0; i_wdata = 32'd0;
        for (int i = 0; i < NWORDS; i++) begin
            ref_mem[i] = $urandom;
            bank_hi[i] = ref_mem[i][31:16];
            bank_lo[i] = ref_mem[i][15:0];
        end
        rst_n = 1'b0;
        #23;
        check_val("rst_ready", {31'd0, o_ready}, 32'd1);
        check_val("rst_done_err", {30'd0, o_done, o_err}, 32'd0);
        check_val("rst_rdata", o_rdata, 32'd0);
        check_val("rst_ram", {o_ram_d_hi, o_ram_d_lo}, 32'd0);
        check_val("rst_ram_ctl", {19'd0, o_ram_addr, o_ram_we, o_ram_sel_hi, o_ram_sel_lo}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a word store: write enable drops at once.
        @(negedge clk);
        i_req = 1'b1; i_wr = 1'b1; i_size = 2'd2; i_addr = 12'h020; i_wdata = 32'h01234567;
        @(negedge clk);
        i_req = 1'b0;
        check_val("midwr_we", {31'd0, o_ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_we", {31'd0, o_ram_we}, 32'd0);
        check_val("midrst_ready", {31'd0, o_ready}, 32'd1);
        check_val("midrst_done", {31'd0, o_done}, 32'd0);
        check_val("midrst_rdata", o_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst_mem", {bank_hi[8], bank_lo[8]}, ref_mem[8]);

        // Directed sequence.
        do_access(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
        do_access(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        check_val("tp_word", o_rdata, 32'hDEADBEEF);
        do_access(1'b1, 2'd0, 1'b0, 12'h013, 32'h00000012);
        do_access(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        check_val("tp_rmw", o_rdata, 32'hDEADBE12);
        do_access(1'b0, 2'd0, 1'b1, 12'h010, 32'h0);
        check_val("tp_sb", o_rdata, 32'hFFFFFFDE);
        do_access(1'b0, 2'd0, 1'b0, 12'h010, 32'h0);
        check_val("tp_zb", o_rdata, 32'h000000DE);
        do_access(1'b0, 2'd1, 1'b1, 12'h012, 32'h0);
        check_val("tp_sh", o_rdata, 32'hFFFFBE12);
        do_access(1'b1, 2'd2, 1'b0, 12'h011, 32'hCAFEF00D);
        check_val("tp_mis_rd", o_rdata, 32'hFFFFBE12);
        check_val("tp_mis_mem", {bank_hi[4], bank_lo[4]}, 32'hDEADBE12);

        // Request held high: accepted only when idle, loads every 3 cycles.
        i_req = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_sext = 1'b0; i_addr = 12'h010;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (o_done) idx_q.push_back(c);
            if (o_ready && o_done) check_val("busy_rdy_done", 32'd1, 32'd0);
        end
        check_val("busy_ld_cnt", (idx_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < idx_q.size(); i++) check_val("busy_ld_gap", idx_q[i] - idx_q[i-1], 3);
        idx_q.delete();
        exp_rdata = 32'hDEADBE12;
        // Byte stores held high: one every 4 cycles.
        i_wr = 1'b1; i_size = 2'd0; i_addr = 12'h013; i_wdata = 32'h00000012;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (o_done) idx_q.push_back(c);
        end
        check_val("busy_sb_cnt", (idx_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < idx_q.size(); i++) check_val("busy_sb_gap", idx_q[i] - idx_q[i-1], 4);
        i_req = 1'b0;
        check_val("busy_rdata", o_rdata, exp_rdata);

        // Randomized accesses, mostly in a small window to hit recent writes.
        for (int t = 0; t < 300; t++) begin
            logic [11:0] a;
            a = ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            do_access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
